ipdb_sar_eoc_capture: RTL
=========================

// Module: ipdb_sar_eoc_capture
// PURPOSE
// - Brings a finished SAR conversion from the asynchronous SAR logic into the clk_i domain.
// - eoc_async_i passes through the internal two-flop synchronizer (ipdb_common_sync).
// - A rising edge on the synchronized signal starts a capture of the quasi-static result bus.
// - The captured result goes to the digital back-end over a valid/ready handshake, with overrun detection and counting.
// PARAMETERS
// - DATA_W      12  width of the SAR result bus
// - SETTLE_CYC  1   clk_i cycles to wait after edge detect before sampling data_async_i; legal range >= 1
// - OVR_CNT_W   8   width of the saturating overrun counter
// PORTS
// - clk_i         in   1          destination clock
// - reset_n_i     in   1          reset, asynchronous, active-low
// - eoc_async_i   in   1          end-of-conversion level from SAR; asynchronous to clk_i
// - data_async_i  in   DATA_W     SAR result; stable from eoc rise until the next conversion starts
// - res_ready_i   in   1          consumer accepts the result
// - res_valid_o   out  1          res_data_o holds an unconsumed result
// - res_data_o    out  DATA_W     captured result
// - busy_o        out  1          FSM not in IDLE
// - overrun_o     out  1          sticky flag: a conversion result was dropped
// - ovr_cnt_o     out  OVR_CNT_W  number of dropped results, saturating
// - ovr_clr_i     in   1          synchronous clear of overrun_o and ovr_cnt_o
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; synchronizer, edge register and settle counter all 0.
// - Reset takes effect asynchronously at any time, including mid-SETTLE or mid-VALID; any pending result is discarded.
// - Synchronization and edge detection:
//   - eoc_s is the ipdb_common_sync output; eoc_d is eoc_s delayed by one flop.
//   - rise = eoc_s & ~eoc_d, so only edges count; a level held high produces exactly one capture.
//   - eoc_d resets to 0, so eoc_async_i already high at reset release counts as one new conversion.
// - FSM states: IDLE, SETTLE, VALID.
//   - IDLE -> SETTLE on rise; the settle counter loads SETTLE_CYC-1.
//   - SETTLE: counter decrements each cycle. At the edge where the counter is 0:
//     - res_data_o <= data_async_i;
//     - res_valid_o <= 1;
//     - next state is VALID.
//   - VALID: res_valid_o and res_data_o hold until res_valid_o & res_ready_i.
//     - On that handshake: go to SETTLE if rise is high in the same cycle, otherwise go to IDLE.
//     - res_valid_o drops the cycle after the handshake.
// - Latency: eoc_async_i is first sampled high at clk edge E0.
//   - eoc_s goes high after E1; rise is high in the cycle following E1.
//   - SETTLE is entered at E2; res_valid_o goes high after edge E(2+SETTLE_CYC).
//   - For SETTLE_CYC=1, valid is high after E3.
// - Overrun: a rise while in SETTLE, or in VALID without a same-cycle handshake, is an overrun.
//   - The new result is dropped; res_data_o and the FSM are unaffected.
//   - overrun_o <= 1 (sticky).
//   - ovr_cnt_o increments and saturates at 2^OVR_CNT_W-1.
// - ovr_clr_i: clears overrun_o and ovr_cnt_o.
//   - If an overrun occurs in the same cycle, the result is ovr_cnt_o=1 and overrun_o=1.
// - res_ready_i is ignored outside VALID.
// - data_async_i is sampled only at the SETTLE->VALID edge.
// - System requirement: the SAR holds data for at least SETTLE_CYC+3 clk_i periods after eoc rises.
// TESTING
// - T1 single conversion: SETTLE_CYC=1, data=12'hA5C, eoc rises before E0, res_ready_i=1.
//   -> res_valid_o is 1 for exactly one cycle, after E3; res_data_o=12'hA5C; busy_o is 0 afterwards.
// - T2 backpressure: res_ready_i=0 for 20 cycles; a second eoc pulse with data=12'h123 arrives during VALID.
//   -> res_data_o stays 12'hA5C; overrun_o=1; ovr_cnt_o=1; one result is delivered once ready=1.
// - T3 saturation: OVR_CNT_W=2, 5 overruns.
//   -> ovr_cnt_o=3.
//   -> ovr_clr_i pulse gives ovr_cnt_o=0 and overrun_o=0.
//   -> ovr_clr_i together with an overrun gives ovr_cnt_o=1.
// - T4 simultaneous: the handshake cycle coincides with rise.
//   -> overrun_o stays 0; the new result (12'h3FF) is valid SETTLE_CYC cycles later.
// - T5 reset mid-SETTLE with eoc low at release.
//   -> all outputs 0 immediately; no capture after release.
// - T6 eoc held high for 100 cycles with ready=1.
//   -> exactly one result delivered.

Source files
------------

// File: rtl/ipdb_sar_eoc_capture.sv
// SAR end-of-conversion capture: synchronizes the asynchronous EOC level, samples the
// quasi-static result bus after a settle delay, and offers it over valid/ready with overrun tracking.

module ipdb_common_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;

   // NOTE: non-blocking assignments keep both flops sampling the pre-edge value, so the
   // chain really is two stages deep; blocking here would collapse it into one.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         meta_q <= '0;
         q_o    <= '0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end

endmodule

module ipdb_sar_eoc_capture #(
   parameter int DATA_W     = 12,
   parameter int SETTLE_CYC = 1,
   parameter int OVR_CNT_W  = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 eoc_async_i,
   input  logic [DATA_W-1:0]    data_async_i,
   input  logic                 res_ready_i,
   output logic                 res_valid_o,
   output logic [DATA_W-1:0]    res_data_o,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic [OVR_CNT_W-1:0] ovr_cnt_o,
   input  logic                 ovr_clr_i
);

   localparam int                   CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [OVR_CNT_W-1:0] OVR_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      VALID  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             eoc_s, eoc_d, rise;
   logic [CNT_W-1:0] cnt_q;
   logic             load_cnt, capture, deliver, overrun_evt;

   ipdb_common_sync #(.WIDTH(1)) u_eoc_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (eoc_async_i),
      .q_o       (eoc_s)
   );

   // eoc_d resets low so a level already high at reset release still counts as one edge.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) eoc_d <= 1'b0;
      else            eoc_d <= eoc_s;
   end

   assign rise = eoc_s & ~eoc_d;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // NOTE: every signal gets its default before the case; a path that skipped one would
   // infer a latch.
   always_comb begin
      state_d     = state_q;
      load_cnt    = 1'b0;
      capture     = 1'b0;
      deliver     = 1'b0;
      overrun_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d  = SETTLE;
               load_cnt = 1'b1;
            end
         end
         SETTLE: begin
            overrun_evt = rise;
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (res_ready_i) begin
               deliver = 1'b1;
               if (rise) begin
                  state_d  = SETTLE;
                  load_cnt = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               overrun_evt = rise;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else if (load_cnt) begin
         cnt_q <= CNT_LOAD;
      end else if (state_q == SETTLE && cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // Result register: loaded only at the SETTLE->VALID edge, so a dropped conversion never
   // disturbs a result still waiting for the consumer.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
      end else if (capture) begin
         res_valid_o <= 1'b1;
         res_data_o  <= data_async_i;
      end else if (deliver) begin
         res_valid_o <= 1'b0;
      end
   end

   // A clear coinciding with an overrun leaves exactly that one overrun recorded.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         overrun_o <= 1'b0;
         ovr_cnt_o <= '0;
      end else if (ovr_clr_i) begin
         overrun_o <= overrun_evt;
         ovr_cnt_o <= overrun_evt ? OVR_CNT_W'(1) : '0;
      end else if (overrun_evt) begin
         overrun_o <= 1'b1;
         if (ovr_cnt_o != OVR_MAX) ovr_cnt_o <= ovr_cnt_o + OVR_CNT_W'(1);
      end
   end

   assign busy_o = (state_q != IDLE);

endmodule
